// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style bus receiver.
// Holds the framing state encoding, the instruction prefixes and the address step helper.
package lcd_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        ST_MODE8 = 2'd0,
        ST_HI    = 2'd1,
        ST_LO    = 2'd2
    } frame_state_e;

    localparam logic [7:0] CLEAR   = 8'h01;
    localparam logic [7:0] HOME    = 8'h02;
    localparam logic [7:0] ENTRY   = 8'h04;
    localparam logic [7:0] DISPCTL = 8'h08;
    localparam logic [7:0] SHIFT   = 8'h10;
    localparam logic [7:0] FUNCSET = 8'h20;
    localparam logic [7:0] CGRAM   = 8'h40;
    localparam logic [7:0] DDRAM   = 8'h80;

    // Address counter wraps modulo 128 in both directions.
    function automatic logic [6:0] addr_step(input logic [6:0] addr, input logic up);
        return up ? addr + 7'd1 : addr - 7'd1;
    endfunction

endpackage

// File: rtl/lcd_en_sync.sv
// Synchronises the host strobe, register select and nibble into clk, and flags each
// falling edge of enable together with the rs/nibble captured while it was high.
module lcd_en_sync
    import lcd_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             rs_i,
    input  logic [NIB_W-1:0] data_i,
    output logic             strobe_o,
    output logic             strobe_rs_o,
    output logic [NIB_W-1:0] strobe_nib_o
);

    logic [SYNC_STAGES-1:0] en_sync_q;
    logic [SYNC_STAGES-1:0] rs_sync_q;
    logic [SYNC_STAGES-1:0] vld_q;
    logic [NIB_W-1:0]       data_sync_q [SYNC_STAGES];
    logic                   en_prev_q;
    logic                   armed_q;
    logic                   cap_rs_q;
    logic [NIB_W-1:0]       cap_nib_q;
    logic                   en_s;

    assign en_s = en_sync_q[SYNC_STAGES-1];

    // vld_q tracks which synchroniser stages hold post-reset samples; a strobe is only
    // armed once a genuine low has reached the last stage, so an enable held high across
    // reset release cannot masquerade as a falling edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_sync_q <= '0;
            rs_sync_q <= '0;
            vld_q     <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) data_sync_q[i] <= '0;
            en_prev_q <= 1'b0;
            armed_q   <= 1'b0;
            cap_rs_q  <= 1'b0;
            cap_nib_q <= '0;
        end else begin
            en_sync_q      <= {en_sync_q[SYNC_STAGES-2:0], en_i};
            rs_sync_q      <= {rs_sync_q[SYNC_STAGES-2:0], rs_i};
            vld_q          <= {vld_q[SYNC_STAGES-2:0], 1'b1};
            data_sync_q[0] <= data_i;
            for (int i = 1; i < SYNC_STAGES; i++) data_sync_q[i] <= data_sync_q[i-1];
            en_prev_q <= en_s;
            if (vld_q[SYNC_STAGES-1] && !en_s) armed_q <= 1'b1;
            if (en_s) begin
                cap_rs_q  <= rs_sync_q[SYNC_STAGES-1];
                cap_nib_q <= data_sync_q[SYNC_STAGES-1];
            end
        end
    end

    assign strobe_o     = armed_q & ~en_s & en_prev_q;
    assign strobe_rs_o  = cap_rs_q;
    assign strobe_nib_o = cap_nib_q;

endmodule

// File: rtl/lcd_rx.sv
// HD44780-compatible bus receiver: frames 4/8-bit strobes into bytes, decodes the
// instruction set that affects addressing/mode, and emits character writes.
module lcd_rx
    import lcd_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       rs,
    input  logic [3:0] data,
    output logic       byte_valid,
    output logic       byte_rs,
    output logic [7:0] byte_data,
    output logic       char_we,
    output logic [6:0] char_addr,
    output logic [7:0] char_data,
    output logic [6:0] ddram_addr,
    output logic       four_bit,
    output logic       two_line,
    output logic       display_on
);

    logic             strobe;
    logic             strobe_rs;
    logic [NIB_W-1:0] strobe_nib;

    lcd_en_sync #(.SYNC_STAGES(SYNC_STAGES)) u_en_sync (
        .clk          (clk),
        .reset        (reset),
        .en_i         (en),
        .rs_i         (rs),
        .data_i       (data),
        .strobe_o     (strobe),
        .strobe_rs_o  (strobe_rs),
        .strobe_nib_o (strobe_nib)
    );

    frame_state_e state_q;
    logic [3:0]   hi_q;
    logic         four_bit_q;
    logic         two_line_q;
    logic         display_on_q;
    logic         inc_q;
    logic [6:0]   ddram_q;
    logic         byte_valid_q;
    logic         byte_rs_q;
    logic [7:0]   byte_data_q;
    logic         char_we_q;
    logic [6:0]   char_addr_q;
    logic [7:0]   char_data_q;

    logic         emit_d;
    logic [7:0]   byte_d;

    always_comb begin
        emit_d = 1'b0;
        byte_d = {strobe_nib, 4'h0};
        case (state_q)
            ST_MODE8: emit_d = strobe;
            ST_LO: begin
                emit_d = strobe;
                byte_d = {hi_q, strobe_nib};
            end
            default: emit_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_MODE8;
            hi_q         <= 4'h0;
            four_bit_q   <= 1'b0;
            two_line_q   <= 1'b0;
            display_on_q <= 1'b0;
            inc_q        <= 1'b1;
            ddram_q      <= 7'h00;
            byte_valid_q <= 1'b0;
            byte_rs_q    <= 1'b0;
            byte_data_q  <= 8'h00;
            char_we_q    <= 1'b0;
            char_addr_q  <= 7'h00;
            char_data_q  <= 8'h00;
        end else begin
            byte_valid_q <= 1'b0;
            char_we_q    <= 1'b0;
            if (strobe) begin
                case (state_q)
                    ST_HI: begin
                        hi_q    <= strobe_nib;
                        state_q <= ST_LO;
                    end
                    ST_LO:   state_q <= ST_HI;
                    default: state_q <= state_q;
                endcase
                if (emit_d) begin
                    byte_valid_q <= 1'b1;
                    byte_rs_q    <= strobe_rs;
                    byte_data_q  <= byte_d;
                    if (strobe_rs) begin
                        char_we_q   <= 1'b1;
                        char_addr_q <= ddram_q;
                        char_data_q <= byte_d;
                        ddram_q     <= addr_step(ddram_q, inc_q);
                    end else if (|(byte_d & DDRAM)) begin
                        ddram_q <= byte_d[6:0];
                    end else if (|(byte_d & CGRAM)) begin
                        ddram_q <= ddram_q;
                    end else if (|(byte_d & FUNCSET)) begin
                        // Overrides the HI/LO advance above; two_line is only trusted
                        // once the host has committed to a bus width.
                        state_q    <= byte_d[4] ? ST_MODE8 : ST_HI;
                        four_bit_q <= ~byte_d[4];
                        if (state_q != ST_MODE8) two_line_q <= byte_d[3];
                    end else if (|(byte_d & SHIFT)) begin
                        if (!byte_d[3]) ddram_q <= addr_step(ddram_q, byte_d[2]);
                    end else if (|(byte_d & DISPCTL)) begin
                        display_on_q <= byte_d[2];
                    end else if (|(byte_d & ENTRY)) begin
                        inc_q <= byte_d[1];
                    end else if (|(byte_d & HOME)) begin
                        ddram_q <= 7'h00;
                    end else if (|(byte_d & CLEAR)) begin
                        ddram_q <= 7'h00;
                        inc_q   <= 1'b1;
                    end
                end
            end
        end
    end

    assign byte_valid = byte_valid_q;
    assign byte_rs    = byte_rs_q;
    assign byte_data  = byte_data_q;
    assign char_we    = char_we_q;
    assign char_addr  = char_addr_q;
    assign char_data  = char_data_q;
    assign ddram_addr = ddram_q;
    assign four_bit   = four_bit_q;
    assign two_line   = two_line_q;
    assign display_on = display_on_q;

endmodule

// File: tb/tb_lcd_rx.sv
// Directed bench for lcd_rx: drives HD44780 strobes and checks framing, decode and reset behaviour.
module tb_lcd_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       rs = 1'b0;
    logic [3:0] data = 4'h0;
    logic       byte_valid, byte_rs, char_we, four_bit, two_line, display_on;
    logic [7:0] byte_data, char_data;
    logic [6:0] char_addr, ddram_addr;

    int n_asserts = 0;
    int n_fail    = 0;
    int bv_cnt    = 0;
    int cw_cnt    = 0;
    int bad_pair  = 0;
    logic [7:0] last_byte  = 8'h00;
    logic       last_rs    = 1'b0;
    logic [6:0] last_caddr = 7'h00;
    logic [7:0] last_cdata = 8'h00;

    lcd_rx #(.SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .rs         (rs),
        .data       (data),
        .byte_valid (byte_valid),
        .byte_rs    (byte_rs),
        .byte_data  (byte_data),
        .char_we    (char_we),
        .char_addr  (char_addr),
        .char_data  (char_data),
        .ddram_addr (ddram_addr),
        .four_bit   (four_bit),
        .two_line   (two_line),
        .display_on (display_on)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (byte_valid) begin
            bv_cnt++;
            last_byte = byte_data;
            last_rs   = byte_rs;
        end
        if (char_we) begin
            cw_cnt++;
            last_caddr = char_addr;
            last_cdata = char_data;
            if (!byte_valid) bad_pair++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic strobe(input logic r, input logic [3:0] n);
        @(negedge clk);
        rs = r;
        data = n;
        repeat (2) @(negedge clk);
        en = 1'b1;
        repeat (4) @(negedge clk);
        en = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_byte(input logic r, input logic [7:0] b);
        strobe(r, b[7:4]);
        strobe(r, b[3:0]);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_byte_valid", byte_valid, 1'b0);
        chk("rst_char_we",    char_we, 1'b0);
        chk("rst_byte_data",  byte_data, 8'h00);
        chk("rst_four_bit",   four_bit, 1'b0);
        chk("rst_two_line",   two_line, 1'b0);
        chk("rst_display_on", display_on, 1'b0);
        chk("rst_ddram",      ddram_addr, 7'h00);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Initialisation into 4-bit, two-line, display on
        strobe(1'b0, 4'h3);
        chk("init_cnt1", bv_cnt, 1);
        chk("init_byte1", last_byte, 8'h30);
        strobe(1'b0, 4'h3);
        strobe(1'b0, 4'h3);
        chk("init_cnt3", bv_cnt, 3);
        chk("init_still8", four_bit, 1'b0);
        strobe(1'b0, 4'h2);
        chk("init_cnt4", bv_cnt, 4);
        chk("init_four_bit", four_bit, 1'b1);
        chk("init_two_line_held", two_line, 1'b0);
        send_byte(1'b0, 8'h28);
        chk("init_cnt5", bv_cnt, 5);
        chk("init_byte28", last_byte, 8'h28);
        chk("init_two_line", two_line, 1'b1);
        send_byte(1'b0, 8'h0C);
        chk("init_cnt6", bv_cnt, 6);
        chk("init_display_on", display_on, 1'b1);
        chk("init_four_bit_end", four_bit, 1'b1);

        // Set address then write 'A'
        send_byte(1'b0, 8'h85);
        chk("ddram_set", ddram_addr, 7'h05);
        send_byte(1'b1, 8'h41);
        chk("wr_cnt", cw_cnt, 1);
        chk("wr_bv_cnt", bv_cnt, 8);
        chk("wr_addr", last_caddr, 7'h05);
        chk("wr_data", last_cdata, 8'h41);
        chk("wr_rs", last_rs, 1'b1);
        chk("wr_ddram_after", ddram_addr, 7'h06);

        // Clear, decrement entry mode, write wraps below zero
        send_byte(1'b0, 8'h01);
        chk("clear_ddram", ddram_addr, 7'h00);
        send_byte(1'b0, 8'h04);
        send_byte(1'b1, 8'h42);
        chk("dec_wr_cnt", cw_cnt, 2);
        chk("dec_wr_addr", last_caddr, 7'h00);
        chk("dec_wr_data", last_cdata, 8'h42);
        chk("dec_ddram_wrap", ddram_addr, 7'h7F);

        // Cursor shifts
        send_byte(1'b0, 8'h14);
        chk("shift_right_wrap", ddram_addr, 7'h00);
        send_byte(1'b0, 8'h1C);
        chk("shift_display_noop", ddram_addr, 7'h00);
        send_byte(1'b0, 8'h10);
        chk("shift_left_wrap", ddram_addr, 7'h7F);
        send_byte(1'b0, 8'h08);
        chk("display_off", display_on, 1'b0);
        chk("bv_cnt_15", bv_cnt, 15);

        // Reset between the halves of 0x48
        strobe(1'b1, 4'h4);
        chk("half_no_emit", bv_cnt, 15);
        pulse_reset();
        chk("midrst_four_bit", four_bit, 1'b0);
        chk("midrst_ddram", ddram_addr, 7'h00);
        chk("midrst_two_line", two_line, 1'b0);
        strobe(1'b1, 4'h4);
        chk("midrst_cnt", bv_cnt, 16);
        chk("midrst_byte", last_byte, 8'h40);
        chk("midrst_rs", last_rs, 1'b1);
        chk("midrst_wr_addr", last_caddr, 7'h00);
        chk("midrst_ddram_after", ddram_addr, 7'h01);

        // Enable held high across reset release
        @(negedge clk);
        en = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        en = 1'b0;
        repeat (10) @(negedge clk);
        chk("held_en_no_strobe", bv_cnt, 16);
        strobe(1'b1, 4'h5);
        chk("held_en_next_cnt", bv_cnt, 17);
        chk("held_en_next_byte", last_byte, 8'h50);
        chk("held_en_wr_addr", last_caddr, 7'h00);
        chk("held_en_ddram", ddram_addr, 7'h01);
        chk("char_we_with_byte_valid", bad_pair, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
